// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the hashing-core clock-enable scheduler.
package clk_div_pkg;

    localparam int DEF_DIV_W       = 8;
    localparam int DEF_DEFAULT_DIV = 2;
    localparam int CLAMP_W         = 32;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    // A ratio of zero would never end a period, so it is promoted to one.
    function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] div);
        return (div == '0) ? CLAMP_W'(1) : div;
    endfunction

endpackage

// File: rtl/rr_ptr.sv
// Round-robin core pointer: advances on request, wraps at N, and decodes one-hot.
module rr_ptr #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         advance_i,
    output logic [W-1:0] ptr_o,
    output logic [N-1:0] onehot_o
);

    logic [W-1:0] ptr_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
        end
    end

    // NOTE: the default before the indexed write keeps this block free of latches.
    always_comb begin
        onehot_o        = '0;
        onehot_o[ptr_q] = 1'b1;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divides clk_in by a runtime ratio and hands a one-cycle enable to each core in turn.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEFAULT_DIV = DEF_DEFAULT_DIV,
    parameter int N_CORES     = 4,
    parameter int CORE_W      = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               run_en,
    input  logic               throttle,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic [N_CORES-1:0] clk_en,
    output logic               tick,
    output logic [CORE_W-1:0]  core_idx,
    output logic [DIV_W-1:0]   cur_div,
    output logic               busy
);

    localparam int CNT_W = DIV_W + 1;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DIV_W-1:0]     cur_div_q;
    logic [DIV_W-1:0]     pend_div_q;
    logic                 tick_q;
    logic [N_CORES-1:0]   clk_en_q;
    logic [CORE_W-1:0]    core_idx_q;

    logic [CNT_W-1:0]     eff;
    logic                 at_bound;
    logic                 fire;
    logic                 xfer;
    logic [DIV_W-1:0]     cfg_div_d;
    logic [CORE_W-1:0]    ptr;
    logic [N_CORES-1:0]   ptr_onehot;

    always_comb begin
        // One extra bit keeps 2*cur_div from wrapping under throttle.
        eff       = throttle ? {cur_div_q, 1'b0} : {1'b0, cur_div_q};
        at_bound  = (cnt_q >= eff - CNT_W'(1));
        fire      = (state_q != STOP) && run_en && at_bound;
        xfer      = cfg_valid && cfg_ready;
        cfg_div_d = DIV_W'(clamp_div(CLAMP_W'(cfg_div)));
    end

    rr_ptr #(
        .N (N_CORES),
        .W (CORE_W)
    ) u_rr_ptr (
        .clk_in    (clk_in),
        .reset     (reset),
        .advance_i (fire),
        .ptr_o     (ptr),
        .onehot_o  (ptr_onehot)
    );

    // NOTE: reset is synchronous and active-low, so it is qualified inside the clocked branch.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q    <= STOP;
            cnt_q      <= '0;
            cur_div_q  <= DIV_W'(DEFAULT_DIV);
            pend_div_q <= '0;
            tick_q     <= 1'b0;
            clk_en_q   <= '0;
            core_idx_q <= '0;
        end else begin
            tick_q   <= fire;
            clk_en_q <= fire ? ptr_onehot : '0;
            if (fire) begin
                core_idx_q <= ptr;
            end

            case (state_q)
                STOP: begin
                    cnt_q <= '0;
                    if (xfer) begin
                        cur_div_q <= cfg_div_d;
                    end
                    if (run_en) begin
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    if (!run_en) begin
                        // Leaving with no period in flight, so an update lands directly.
                        state_q <= STOP;
                        cnt_q   <= '0;
                        if (xfer) begin
                            cur_div_q <= cfg_div_d;
                        end
                    end else begin
                        cnt_q <= at_bound ? '0 : cnt_q + CNT_W'(1);
                        if (xfer) begin
                            pend_div_q <= cfg_div_d;
                            state_q    <= PEND;
                        end
                    end
                end

                PEND: begin
                    if (!run_en) begin
                        cur_div_q <= pend_div_q;
                        cnt_q     <= '0;
                        state_q   <= STOP;
                    end else if (at_bound) begin
                        cur_div_q <= pend_div_q;
                        cnt_q     <= '0;
                        state_q   <= RUN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= STOP;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign cfg_ready = (state_q != PEND);
    assign busy      = (state_q == PEND);
    assign tick      = tick_q;
    assign clk_en    = clk_en_q;
    assign core_idx  = core_idx_q;
    assign cur_div   = cur_div_q;

endmodule
